// File: rtl/iob_cache_read_channel_axi_cwf.sv
// -----------------------------------------------------------------------------
// iob_cache_read_channel_axi_cwf
//
// AXI4 read back-end for cache-line replacement. A fill request latches the
// missed beat address, issues one AR burst covering the whole line and streams
// each returned beat straight to the cache line write port.
//
// BURST_MODE = 0 : line-aligned INCR burst, beats return in order 0..NBEATS-1.
// BURST_MODE = 1 : critical-word-first WRAP burst starting at the missed beat
//                  (used only when 1 <= LINE2BE_W <= 4, otherwise INCR).
//
// Optional feature, macro IOB_CACHE_AXI_RERR_EN: adds read_err_o, a one-cycle
// pulse after a burst that carried a non-OKAY rresp or an rlast mismatch.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   replace_valid_i         line-fill request (sampled in IDLE only)
//   replace_addr_i          beat address of the missed word
//   replace_o               fill in progress
//   read_valid_o            beat valid towards the cache line write
//   read_addr_o             beat index within the line
//   read_rdata_o            beat data
//   read_err_o              (IOB_CACHE_AXI_RERR_EN only) burst error pulse
//   axi_ar*                 AXI4 read address channel
//   axi_r*                  AXI4 read data channel
// -----------------------------------------------------------------------------
module iob_cache_read_channel_axi_cwf #(
   parameter int FE_ADDR_W  = 32,
   parameter int BE_ADDR_W  = 32,
   parameter int BE_DATA_W  = 32,
   parameter int LINE2BE_W  = 2,
   parameter int BURST_MODE = 0,
   parameter int AXI_ID_W   = 1,
   parameter int AXI_ID     = 0,
   parameter int AXI_LEN_W  = 8,
   localparam int BE_NBYTES_W = $clog2(BE_DATA_W / 8),
   localparam int RA_MSB      = (LINE2BE_W > 0) ? LINE2BE_W - 1 : 0
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic                               replace_valid_i,
   input  logic [FE_ADDR_W-BE_NBYTES_W-1:0]   replace_addr_i,
   output logic                               replace_o,
   output logic                               read_valid_o,
   output logic [RA_MSB:0]                    read_addr_o,
   output logic [BE_DATA_W-1:0]               read_rdata_o,
`ifdef IOB_CACHE_AXI_RERR_EN
   output logic                               read_err_o,
`endif
   output logic [AXI_ID_W-1:0]                axi_arid_o,
   output logic [BE_ADDR_W-1:0]               axi_araddr_o,
   output logic [AXI_LEN_W-1:0]               axi_arlen_o,
   output logic [2:0]                         axi_arsize_o,
   output logic [1:0]                         axi_arburst_o,
   output logic                               axi_arlock_o,
   output logic [3:0]                         axi_arcache_o,
   output logic [2:0]                         axi_arprot_o,
   output logic [3:0]                         axi_arqos_o,
   output logic                               axi_arvalid_o,
   input  logic                               axi_arready_i,
   input  logic [AXI_ID_W-1:0]                axi_rid_i,
   input  logic [BE_DATA_W-1:0]               axi_rdata_i,
   input  logic [1:0]                         axi_rresp_i,
   input  logic                               axi_rlast_i,
   input  logic                               axi_rvalid_i,
   output logic                               axi_rready_o
);

   localparam int BA_W   = FE_ADDR_W - BE_NBYTES_W;
   localparam int CNT_W  = RA_MSB + 1;
   localparam int NBEATS = 1 << LINE2BE_W;
   localparam bit WRAP_EN = (BURST_MODE == 1) && (LINE2BE_W >= 1) && (LINE2BE_W <= 4);
   localparam logic [BA_W-1:0]  LINE_MASK = ~BA_W'((1 << LINE2BE_W) - 1);
   // With LINE2BE_W = 0 the counters are kept 1 bit wide; masking with
   // NBEATS-1 pins them to 0 so the single-beat case needs no special path.
   localparam logic [CNT_W-1:0] BEAT_MASK = CNT_W'(NBEATS - 1);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
   state_t state, state_nxt;

   logic [BA_W-1:0]      addr_q;
   logic [CNT_W-1:0]     beat_q;
   logic [CNT_W-1:0]     recv_q;
   logic [CNT_W-1:0]     start_beat;
   logic [BA_W-1:0]      burst_beat_addr;
   logic [FE_ADDR_W-1:0] burst_byte_addr;
   logic                 ar_hs;
   logic                 r_hs;
   logic                 last_beat;

   assign ar_hs     = (state == ADDR) && axi_arready_i;
   assign r_hs      = (state == DATA) && axi_rvalid_i;
   // Termination follows the local beat count, not rlast.
   assign last_beat = (recv_q == BEAT_MASK);

   assign start_beat      = WRAP_EN ? (CNT_W'(addr_q) & BEAT_MASK) : '0;
   assign burst_beat_addr = WRAP_EN ? addr_q : (addr_q & LINE_MASK);
   assign burst_byte_addr = {burst_beat_addr, {BE_NBYTES_W{1'b0}}};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (replace_valid_i) state_nxt = ADDR;
         ADDR:    if (axi_arready_i) state_nxt = DATA;
         DATA:    if (r_hs && last_beat) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         addr_q <= '0;
         beat_q <= '0;
         recv_q <= '0;
      end else begin
         if ((state == IDLE) && replace_valid_i) begin
            addr_q <= replace_addr_i;
         end
         if (ar_hs) begin
            beat_q <= start_beat;
            recv_q <= '0;
         end else if (r_hs) begin
            beat_q <= (beat_q + 1'b1) & BEAT_MASK;
            recv_q <= recv_q + 1'b1;
         end
      end
   end

   // AR fields are driven only while the request is presented, so every
   // channel output reads 0 outside the address phase (including reset).
   assign replace_o     = (state != IDLE);
   assign axi_arvalid_o = (state == ADDR);
   assign axi_rready_o  = (state == DATA);
   assign axi_arid_o    = axi_arvalid_o ? AXI_ID_W'(AXI_ID) : '0;
   assign axi_araddr_o  = axi_arvalid_o ? BE_ADDR_W'(burst_byte_addr) : '0;
   assign axi_arlen_o   = axi_arvalid_o ? AXI_LEN_W'(NBEATS - 1) : '0;
   assign axi_arsize_o  = axi_arvalid_o ? 3'(BE_NBYTES_W) : '0;
   assign axi_arburst_o = axi_arvalid_o ? (WRAP_EN ? 2'b10 : 2'b01) : '0;
   assign axi_arlock_o  = 1'b0;
   assign axi_arcache_o = axi_arvalid_o ? 4'b0011 : '0;
   assign axi_arprot_o  = '0;
   assign axi_arqos_o   = '0;

   assign read_valid_o  = r_hs;
   assign read_addr_o   = r_hs ? (beat_q & BEAT_MASK) : '0;
   assign read_rdata_o  = r_hs ? axi_rdata_i : '0;

`ifdef IOB_CACHE_AXI_RERR_EN
   logic err_q;
   logic err_pulse_q;
   logic beat_err;

   assign beat_err = (axi_rresp_i != 2'b00) || (axi_rlast_i != last_beat);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_q       <= 1'b0;
         err_pulse_q <= 1'b0;
      end else begin
         err_pulse_q <= r_hs && last_beat && (err_q || beat_err);
         if ((state == IDLE) && replace_valid_i) begin
            err_q <= 1'b0;
         end else if (r_hs && beat_err) begin
            err_q <= 1'b1;
         end
      end
   end

   assign read_err_o = err_pulse_q;

   logic unused_in;
   assign unused_in = ^{axi_rid_i};
`else
   logic unused_in;
   assign unused_in = ^{axi_rid_i, axi_rresp_i, axi_rlast_i};
`endif

endmodule

// File: tb/tb_iob_cache_read_channel_axi_cwf.sv
// -----------------------------------------------------------------------------
// Bench for iob_cache_read_channel_axi_cwf. Two line-fill instances (INCR and
// WRAP, 4 beats of 32 bits) share one stimulus stream; a third instance with
// BURST_MODE=1, LINE2BE_W=0 covers the single-beat build. Expected values are
// derived from the fill request address and the generated beat data.
// -----------------------------------------------------------------------------
module tb_iob_cache_read_channel_axi_cwf;

   localparam int NB = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // shared stimulus for the two 4-beat instances
   logic        replace_valid;
   logic [29:0] replace_addr;
   logic        arready;
   logic [0:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;

   // INCR instance outputs
   logic        i_replace, i_read_valid, i_arlock, i_arvalid, i_rready;
   logic [1:0]  i_read_addr, i_arburst;
   logic [31:0] i_read_rdata, i_araddr;
   logic [0:0]  i_arid;
   logic [7:0]  i_arlen;
   logic [2:0]  i_arsize, i_arprot;
   logic [3:0]  i_arcache, i_arqos;

   // WRAP instance outputs
   logic        w_replace, w_read_valid, w_arlock, w_arvalid, w_rready;
   logic [1:0]  w_read_addr, w_arburst;
   logic [31:0] w_read_rdata, w_araddr;
   logic [0:0]  w_arid;
   logic [7:0]  w_arlen;
   logic [2:0]  w_arsize, w_arprot;
   logic [3:0]  w_arcache, w_arqos;

   // single-beat instance
   logic        o_replace_valid, o_arready, o_rlast, o_rvalid;
   logic [29:0] o_replace_addr;
   logic [31:0] o_rdata;
   logic        o_replace, o_read_valid, o_arlock, o_arvalid, o_rready;
   logic [0:0]  o_read_addr;
   logic [1:0]  o_arburst;
   logic [31:0] o_read_rdata, o_araddr;
   logic [0:0]  o_arid;
   logic [7:0]  o_arlen;
   logic [2:0]  o_arsize, o_arprot;
   logic [3:0]  o_arcache, o_arqos;

`ifdef IOB_CACHE_AXI_RERR_EN
   logic i_err, w_err, o_err;
`endif

   iob_cache_read_channel_axi_cwf #(.BURST_MODE(0), .LINE2BE_W(2)) u_incr (
      .clk_i(clk), .rst_i(rst),
      .replace_valid_i(replace_valid), .replace_addr_i(replace_addr),
      .replace_o(i_replace), .read_valid_o(i_read_valid),
      .read_addr_o(i_read_addr), .read_rdata_o(i_read_rdata),
`ifdef IOB_CACHE_AXI_RERR_EN
      .read_err_o(i_err),
`endif
      .axi_arid_o(i_arid), .axi_araddr_o(i_araddr), .axi_arlen_o(i_arlen),
      .axi_arsize_o(i_arsize), .axi_arburst_o(i_arburst), .axi_arlock_o(i_arlock),
      .axi_arcache_o(i_arcache), .axi_arprot_o(i_arprot), .axi_arqos_o(i_arqos),
      .axi_arvalid_o(i_arvalid), .axi_arready_i(arready),
      .axi_rid_i(rid), .axi_rdata_i(rdata), .axi_rresp_i(rresp),
      .axi_rlast_i(rlast), .axi_rvalid_i(rvalid), .axi_rready_o(i_rready)
   );

   iob_cache_read_channel_axi_cwf #(.BURST_MODE(1), .LINE2BE_W(2)) u_wrap (
      .clk_i(clk), .rst_i(rst),
      .replace_valid_i(replace_valid), .replace_addr_i(replace_addr),
      .replace_o(w_replace), .read_valid_o(w_read_valid),
      .read_addr_o(w_read_addr), .read_rdata_o(w_read_rdata),
`ifdef IOB_CACHE_AXI_RERR_EN
      .read_err_o(w_err),
`endif
      .axi_arid_o(w_arid), .axi_araddr_o(w_araddr), .axi_arlen_o(w_arlen),
      .axi_arsize_o(w_arsize), .axi_arburst_o(w_arburst), .axi_arlock_o(w_arlock),
      .axi_arcache_o(w_arcache), .axi_arprot_o(w_arprot), .axi_arqos_o(w_arqos),
      .axi_arvalid_o(w_arvalid), .axi_arready_i(arready),
      .axi_rid_i(rid), .axi_rdata_i(rdata), .axi_rresp_i(rresp),
      .axi_rlast_i(rlast), .axi_rvalid_i(rvalid), .axi_rready_o(w_rready)
   );

   iob_cache_read_channel_axi_cwf #(.BURST_MODE(1), .LINE2BE_W(0)) u_one (
      .clk_i(clk), .rst_i(rst),
      .replace_valid_i(o_replace_valid), .replace_addr_i(o_replace_addr),
      .replace_o(o_replace), .read_valid_o(o_read_valid),
      .read_addr_o(o_read_addr), .read_rdata_o(o_read_rdata),
`ifdef IOB_CACHE_AXI_RERR_EN
      .read_err_o(o_err),
`endif
      .axi_arid_o(o_arid), .axi_araddr_o(o_araddr), .axi_arlen_o(o_arlen),
      .axi_arsize_o(o_arsize), .axi_arburst_o(o_arburst), .axi_arlock_o(o_arlock),
      .axi_arcache_o(o_arcache), .axi_arprot_o(o_arprot), .axi_arqos_o(o_arqos),
      .axi_arvalid_o(o_arvalid), .axi_arready_i(o_arready),
      .axi_rid_i(rid), .axi_rdata_i(o_rdata), .axi_rresp_i(rresp),
      .axi_rlast_i(o_rlast), .axi_rvalid_i(o_rvalid), .axi_rready_o(o_rready)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      check({tag, "_i_replace"}, 64'(i_replace), 64'(0));
      check({tag, "_w_replace"}, 64'(w_replace), 64'(0));
      check({tag, "_i_arvalid"}, 64'(i_arvalid), 64'(0));
      check({tag, "_w_arvalid"}, 64'(w_arvalid), 64'(0));
      check({tag, "_i_rready"}, 64'(i_rready), 64'(0));
      check({tag, "_w_rready"}, 64'(w_rready), 64'(0));
      check({tag, "_i_rvalid"}, 64'(i_read_valid), 64'(0));
      check({tag, "_w_rvalid"}, 64'(w_read_valid), 64'(0));
      check({tag, "_i_raddr"}, 64'(i_read_addr), 64'(0));
      check({tag, "_w_raddr"}, 64'(w_read_addr), 64'(0));
      check({tag, "_i_rdata"}, 64'(i_read_rdata), 64'(0));
      check({tag, "_w_rdata"}, 64'(w_read_rdata), 64'(0));
      check({tag, "_i_araddr"}, 64'(i_araddr), 64'(0));
      check({tag, "_w_araddr"}, 64'(w_araddr), 64'(0));
      check({tag, "_i_arlen"}, 64'(i_arlen), 64'(0));
      check({tag, "_w_arlen"}, 64'(w_arlen), 64'(0));
      check({tag, "_i_arburst"}, 64'(i_arburst), 64'(0));
      check({tag, "_w_arburst"}, 64'(w_arburst), 64'(0));
   endtask

   // One complete line fill. rresp_beat / rlast_beat select a beat that gets
   // rresp=SLVERR or an early rlast (-1 = none). Starts at posedge+1.
   task automatic do_fill(input logic [29:0] ba, input int ar_wait, input bit gaps,
                          input int rresp_beat, input int rlast_beat);
      logic [31:0] d [NB];
      logic [31:0] exp_incr, exp_wrap;
      int          start, k, cyc;
      bit          v;
      bit          exp_err;
      for (int j = 0; j < NB; j++) d[j] = $urandom;
      exp_incr = {ba & ~30'd3, 2'b00};
      exp_wrap = {ba, 2'b00};
      start    = int'(ba[1:0]);
      exp_err  = (rresp_beat >= 0) || (rlast_beat >= 0 && rlast_beat < NB - 1);

      @(posedge clk); #1;
      replace_valid = 1'b1;
      replace_addr  = ba;
      @(negedge clk);
      check("req_i_replace", 64'(i_replace), 64'(0));
      check("req_w_replace", 64'(w_replace), 64'(0));
      @(posedge clk); #1;

      for (int c = 0; c <= ar_wait; c++) begin
         // requests presented outside IDLE must not disturb the burst
         replace_valid = (c < ar_wait);
         if (c < ar_wait) replace_addr = 30'($urandom);
         arready = (c == ar_wait);
         @(negedge clk);
         check("ar_i_replace", 64'(i_replace), 64'(1));
         check("ar_w_replace", 64'(w_replace), 64'(1));
         check("ar_i_arvalid", 64'(i_arvalid), 64'(1));
         check("ar_w_arvalid", 64'(w_arvalid), 64'(1));
         check("ar_i_araddr", 64'(i_araddr), 64'(exp_incr));
         check("ar_w_araddr", 64'(w_araddr), 64'(exp_wrap));
         check("ar_i_arlen", 64'(i_arlen), 64'(NB - 1));
         check("ar_w_arlen", 64'(w_arlen), 64'(NB - 1));
         check("ar_i_arburst", 64'(i_arburst), 64'(1));
         check("ar_w_arburst", 64'(w_arburst), 64'(2));
         check("ar_i_arsize", 64'(i_arsize), 64'(2));
         check("ar_w_arsize", 64'(w_arsize), 64'(2));
         check("ar_i_arcache", 64'(i_arcache), 64'(3));
         check("ar_w_arcache", 64'(w_arcache), 64'(3));
         check("ar_i_arid", 64'(i_arid), 64'(0));
         check("ar_i_misc", 64'({i_arlock, i_arprot, i_arqos}), 64'(0));
         check("ar_i_rready", 64'(i_rready), 64'(0));
         check("ar_w_rready", 64'(w_rready), 64'(0));
         @(posedge clk); #1;
      end
      arready       = 1'b0;
      replace_valid = 1'b0;

      k   = 0;
      cyc = 0;
      while (k < NB) begin
         v      = gaps ? (cyc % 2 == 1) : 1'b1;
         rvalid = v;
         rdata  = v ? d[k] : $urandom;
         rresp  = (v && k == rresp_beat) ? 2'b10 : 2'b00;
         rlast  = v && (k == NB - 1 || k == rlast_beat);
         @(negedge clk);
         check("dt_i_replace", 64'(i_replace), 64'(1));
         check("dt_i_rready", 64'(i_rready), 64'(1));
         check("dt_w_rready", 64'(w_rready), 64'(1));
         check("dt_i_arvalid", 64'(i_arvalid), 64'(0));
         check("dt_i_rvalid", 64'(i_read_valid), 64'(v));
         check("dt_w_rvalid", 64'(w_read_valid), 64'(v));
         if (v) begin
            check("dt_i_raddr", 64'(i_read_addr), 64'(k));
            check("dt_w_raddr", 64'(w_read_addr), 64'((start + k) % NB));
            check("dt_i_rdata", 64'(i_read_rdata), 64'(d[k]));
            check("dt_w_rdata", 64'(w_read_rdata), 64'(d[k]));
         end
         @(posedge clk); #1;
         if (v) k++;
         cyc++;
      end
      rvalid = 1'b0;
      rlast  = 1'b0;
      rresp  = 2'b00;
      rdata  = $urandom;
      @(negedge clk);
      chk_idle("end");
`ifdef IOB_CACHE_AXI_RERR_EN
      check("end_i_err", 64'(i_err), 64'(exp_err));
      check("end_w_err", 64'(w_err), 64'(exp_err));
      @(posedge clk); #1;
      @(negedge clk);
      check("post_i_err", 64'(i_err), 64'(0));
      check("post_w_err", 64'(w_err), 64'(0));
`else
      if (exp_err) check("end_noerr_replace", 64'(i_replace), 64'(0));
`endif
   endtask

   task automatic reset_mid();
      @(posedge clk); #1;
      replace_valid = 1'b1;
      replace_addr  = 30'($urandom);
      @(posedge clk); #1;
      replace_valid = 1'b0;
      arready       = 1'b1;
      @(posedge clk); #1;
      arready = 1'b0;
      rvalid  = 1'b1;
      for (int j = 0; j < 2; j++) begin
         rdata = $urandom;
         @(posedge clk); #1;
      end
      rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      check("pre_rst_i_rvalid", 64'(i_read_valid), 64'(1));
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk_idle("rst");
      @(negedge clk);
      rvalid = 1'b0;
      rst    = 1'b0;
   endtask

   task automatic single_beat(input logic [29:0] ba);
      logic [31:0] d;
      d = $urandom;
      @(posedge clk); #1;
      o_replace_valid = 1'b1;
      o_replace_addr  = ba;
      @(posedge clk); #1;
      o_replace_valid = 1'b0;
      o_arready       = 1'b1;
      @(negedge clk);
      check("one_arvalid", 64'(o_arvalid), 64'(1));
      check("one_arlen", 64'(o_arlen), 64'(0));
      check("one_arburst", 64'(o_arburst), 64'(1));
      check("one_araddr", 64'(o_araddr), 64'({ba, 2'b00}));
      check("one_replace", 64'(o_replace), 64'(1));
      @(posedge clk); #1;
      o_arready = 1'b0;
      o_rvalid  = 1'b1;
      o_rlast   = 1'b1;
      o_rdata   = d;
      @(negedge clk);
      check("one_rvalid", 64'(o_read_valid), 64'(1));
      check("one_raddr", 64'(o_read_addr), 64'(0));
      check("one_rdata", 64'(o_read_rdata), 64'(d));
      check("one_rready", 64'(o_rready), 64'(1));
      @(posedge clk); #1;
      o_rvalid = 1'b0;
      o_rlast  = 1'b0;
      @(negedge clk);
      check("one_end_replace", 64'(o_replace), 64'(0));
      check("one_end_rvalid", 64'(o_read_valid), 64'(0));
`ifdef IOB_CACHE_AXI_RERR_EN
      check("one_end_err", 64'(o_err), 64'(0));
`endif
   endtask

   initial begin
      rst             = 1'b1;
      replace_valid   = 1'b0;
      replace_addr    = '0;
      arready         = 1'b0;
      rid             = '0;
      rdata           = '0;
      rresp           = '0;
      rlast           = 1'b0;
      rvalid          = 1'b0;
      o_replace_valid = 1'b0;
      o_replace_addr  = '0;
      o_arready       = 1'b0;
      o_rdata         = '0;
      o_rlast         = 1'b0;
      o_rvalid        = 1'b0;
      #12;
      chk_idle("reset");
      check("reset_o_replace", 64'(o_replace), 64'(0));
      check("reset_o_araddr", 64'(o_araddr), 64'(0));
      @(negedge clk);
      rst = 1'b0;

      // byte address 0x8000_0038 -> beat address 0x2000_000E
      do_fill(30'h2000_000E, 0, 1'b0, -1, -1);
      do_fill(30'($urandom), 5, 1'b1, -1, -1);
      do_fill(30'($urandom), 1, 1'b0, 1, -1);
      do_fill(30'($urandom), 0, 1'b1, -1, -1);
      do_fill(30'($urandom), 2, 1'b0, -1, 0);
      reset_mid();
      do_fill(30'($urandom), 0, 1'b0, -1, -1);
      single_beat(30'($urandom));
      for (int n = 0; n < 4; n++) begin
         do_fill(30'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1, -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
